fluxo_dados_exp6: RTL and testbench

//  Datapath paired with the exp6 game control unit (the Moore FSM that drives the zera*/conta*/registraR strobes).
//  - Consumes those strobes; returns status flags fimE, fimRod, fimT, igual, enderecoIgualRodada and the jogada pulse.
//  - Holds address/round/timeout counters, the player-move register, a fixed 16x4 sequence ROM,
//    a comparator and the button edge detector.

---
 rtl/fluxo_dados_exp6.sv | 84 ++++++++
 tb/tb_fluxo_dados_exp6.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_exp6.sv
// fluxo_dados_exp6: datapath for the exp6 game control unit.
// Holds the address counter E, the round counter Rod, the timeout counter T,
// the player-move register R, a fixed 16x4 sequence ROM, a comparator and the button edge detector.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   botoes[3:0]                  player buttons
//   zeraE/contaE                 clear/increment E (clear wins)
//   zeraRod/contaRod             clear/increment Rod (clear wins)
//   zeraT/contaT                 clear/increment T, saturating at TIMEOUT-1 (clear wins)
//   zeraR/registraR              clear/load R from botoes (clear wins)
//   jogada                       one-cycle pulse on the rising edge of |botoes
//   igual                        ROM[E] == R
//   enderecoIgualRodada          E == Rod
//   fimE, fimRod, fimT           E == F, Rod == F, T == TIMEOUT-1
//   db_contagem, db_rodada       E, Rod
//   db_memoria, db_jogada        ROM[E], R
//   db_tem_jogada                raw |botoes
module fluxo_dados_exp6 #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    botoes,
    input  logic          zeraE,
    input  logic          contaE,
    input  logic          zeraRod,
    input  logic          contaRod,
    input  logic          zeraT,
    input  logic          contaT,
    input  logic          zeraR,
    input  logic          registraR,
    output logic          jogada,
    output logic          igual,
    output logic          enderecoIgualRodada,
    output logic          fimE,
    output logic          fimRod,
    output logic          fimT,
    output logic [3:0]    db_contagem,
    output logic [3:0]    db_rodada,
    output logic [3:0]    db_memoria,
    output logic [3:0]    db_jogada,
    output logic          db_tem_jogada
);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);
    // Sequence ROM packed with address F in the top nibble and address 0 in the bottom nibble.
    localparam logic [63:0] ROM = {4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
                                   4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

    logic [3:0]    contagem, rodada, regJogada, memoria;
    logic [TW-1:0] tempo;
    logic          temJogada, prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem  <= 4'h0;
            rodada    <= 4'h0;
            tempo     <= '0;
            regJogada <= 4'h0;
        end else begin
            contagem  <= zeraE ? 4'h0 : contaE ? contagem + 4'h1 : contagem;
            rodada    <= zeraRod ? 4'h0 : contaRod ? rodada + 4'h1 : rodada;
            tempo     <= zeraT ? '0 : (contaT && tempo != T_MAX) ? tempo + TW'(1) : tempo;
            regJogada <= zeraR ? 4'h0 : registraR ? botoes : regJogada;
        end
        // prev keeps tracking the buttons through reset, so a key held across reset
        // is seen as already pressed and produces no pulse until released and pressed again.
        prev <= temJogada;
    end

    assign temJogada           = |botoes;
    assign jogada              = temJogada & ~prev & ~reset;
    assign memoria             = ROM[{contagem, 2'b00} +: 4];
    assign igual               = memoria == regJogada;
    assign enderecoIgualRodada = contagem == rodada;
    assign fimE                = contagem == 4'hF;
    assign fimRod              = rodada == 4'hF;
    assign fimT                = tempo == T_MAX;
    assign db_contagem         = contagem;
    assign db_rodada           = rodada;
    assign db_memoria          = memoria;
    assign db_jogada           = regJogada;
    assign db_tem_jogada       = temJogada;
endmodule

// File: tb/tb_fluxo_dados_exp6.sv
// tb_fluxo_dados_exp6: directed self-checking bench for fluxo_dados_exp6 with TIMEOUT=8.
module tb_fluxo_dados_exp6;
    logic       clock = 1'b0, reset = 1'b0;
    logic [3:0] botoes = 4'h0;
    logic       zeraE = 0, contaE = 0, zeraRod = 0, contaRod = 0;
    logic       zeraT = 0, contaT = 0, zeraR = 0, registraR = 0;
    logic       jogada, igual, enderecoIgualRodada, fimE, fimRod, fimT, db_tem_jogada;
    logic [3:0] db_contagem, db_rodada, db_memoria, db_jogada;
    int         checks = 0, errors = 0;

    fluxo_dados_exp6 #(.TIMEOUT(8), .TW(4)) dut (
        .clock(clock), .reset(reset), .botoes(botoes),
        .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
        .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
        .jogada(jogada), .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
        .fimE(fimE), .fimRod(fimRod), .fimT(fimT),
        .db_contagem(db_contagem), .db_rodada(db_rodada), .db_memoria(db_memoria),
        .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1; zeraE = 1; contaE = 1; zeraRod = 1; contaRod = 1;
        zeraT = 1; contaT = 1; zeraR = 1; registraR = 1; botoes = 4'h0;
        tick(2);
        checks++; if (db_contagem !== 4'h0) begin errors++; $display("FAIL reset_E got %h exp 0", db_contagem); end
        checks++; if (db_rodada !== 4'h0) begin errors++; $display("FAIL reset_Rod got %h exp 0", db_rodada); end
        checks++; if (db_jogada !== 4'h0) begin errors++; $display("FAIL reset_R got %h exp 0", db_jogada); end
        checks++; if (fimT !== 1'b0) begin errors++; $display("FAIL reset_fimT got %b exp 0", fimT); end
        checks++; if (enderecoIgualRodada !== 1'b1) begin errors++; $display("FAIL reset_eqRod got %b exp 1", enderecoIgualRodada); end
        checks++; if (igual !== 1'b0) begin errors++; $display("FAIL reset_igual got %b exp 0", igual); end
        checks++; if (jogada !== 1'b0) begin errors++; $display("FAIL reset_jogada got %b exp 0", jogada); end
        checks++; if (db_memoria !== 4'h1) begin errors++; $display("FAIL reset_mem got %h exp 1", db_memoria); end
        reset = 0; zeraE = 0; contaE = 0; zeraRod = 0; contaRod = 0;
        zeraT = 0; contaT = 0; zeraR = 0; registraR = 0;
        tick();
    endtask

    task automatic test_contaE;
        contaE = 1; tick(15); contaE = 0;
        checks++; if (db_contagem !== 4'hF) begin errors++; $display("FAIL contaE_15 got %h exp F", db_contagem); end
        checks++; if (fimE !== 1'b1) begin errors++; $display("FAIL fimE_at_F got %b exp 1", fimE); end
        checks++; if (db_memoria !== 4'h4) begin errors++; $display("FAIL rom_F got %h exp 4", db_memoria); end
        contaE = 1; tick(); contaE = 0;
        checks++; if (db_contagem !== 4'h0) begin errors++; $display("FAIL contaE_wrap got %h exp 0", db_contagem); end
        checks++; if (fimE !== 1'b0) begin errors++; $display("FAIL fimE_wrap got %b exp 0", fimE); end
        contaE = 1; tick(2);
        zeraE = 1; tick(); zeraE = 0; contaE = 0;
        checks++; if (db_contagem !== 4'h0) begin errors++; $display("FAIL zeraE_prio got %h exp 0", db_contagem); end
    endtask

    task automatic test_jogada;
        int pulses = 0;
        botoes = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (jogada === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL held_key_pulses got %0d exp 1", pulses); end
        checks++; if (db_tem_jogada !== 1'b1) begin errors++; $display("FAIL tem_jogada got %b exp 1", db_tem_jogada); end
        registraR = 1; tick(); registraR = 0;
        checks++; if (db_jogada !== 4'b0001) begin errors++; $display("FAIL registraR got %h exp 1", db_jogada); end
        checks++; if (igual !== 1'b1) begin errors++; $display("FAIL igual_E0 got %b exp 1", igual); end
        botoes = 4'b0100; registraR = 1; tick(); registraR = 0;
        checks++; if (igual !== 1'b0) begin errors++; $display("FAIL igual_0100 got %b exp 0", igual); end
        checks++; if (jogada !== 1'b0) begin errors++; $display("FAIL key_change_no_pulse got %b exp 0", jogada); end
        zeraR = 1; registraR = 1; tick(); zeraR = 0; registraR = 0;
        checks++; if (db_jogada !== 4'h0) begin errors++; $display("FAIL zeraR_prio got %h exp 0", db_jogada); end
        botoes = 4'h0; tick();
        botoes = 4'b0010; #1;
        checks++; if (jogada !== 1'b1) begin errors++; $display("FAIL repress_pulse got %b exp 1", jogada); end
        tick();
        checks++; if (jogada !== 1'b0) begin errors++; $display("FAIL repress_one_cycle got %b exp 0", jogada); end
        botoes = 4'h0; tick();
    endtask

    task automatic test_timeout;
        zeraT = 1; tick(); zeraT = 0;
        contaT = 1; tick(6);
        checks++; if (fimT !== 1'b0) begin errors++; $display("FAIL fimT_at_6 got %b exp 0", fimT); end
        tick();
        checks++; if (fimT !== 1'b1) begin errors++; $display("FAIL fimT_at_7 got %b exp 1", fimT); end
        tick(5);
        checks++; if (fimT !== 1'b1) begin errors++; $display("FAIL fimT_saturate got %b exp 1", fimT); end
        contaT = 0; zeraT = 1; tick(); zeraT = 0;
        checks++; if (fimT !== 1'b0) begin errors++; $display("FAIL zeraT got %b exp 0", fimT); end
    endtask

    task automatic test_rodada;
        zeraE = 1; zeraRod = 1; tick(); zeraE = 0; zeraRod = 0;
        contaRod = 1; tick(3); contaRod = 0;
        checks++; if (db_rodada !== 4'h3) begin errors++; $display("FAIL rod_3 got %h exp 3", db_rodada); end
        contaE = 1; tick(3); contaE = 0;
        checks++; if (enderecoIgualRodada !== 1'b1) begin errors++; $display("FAIL eqRod_E3 got %b exp 1", enderecoIgualRodada); end
        contaE = 1; tick(); contaE = 0;
        checks++; if (enderecoIgualRodada !== 1'b0) begin errors++; $display("FAIL eqRod_E4 got %b exp 0", enderecoIgualRodada); end
        contaE = 1; tick(2); contaE = 0;
        checks++; if (db_memoria !== 4'h1) begin errors++; $display("FAIL rom_6 got %h exp 1", db_memoria); end
        contaE = 1; tick(6); contaE = 0;
        checks++; if (db_memoria !== 4'h8) begin errors++; $display("FAIL rom_12 got %h exp 8", db_memoria); end
        checks++; if (fimRod !== 1'b0) begin errors++; $display("FAIL fimRod_3 got %b exp 0", fimRod); end
        contaRod = 1; tick(12); contaRod = 0;
        checks++; if (fimRod !== 1'b1) begin errors++; $display("FAIL fimRod_F got %b exp 1", fimRod); end
        contaRod = 1; zeraRod = 1; tick(); contaRod = 0; zeraRod = 0;
        checks++; if (db_rodada !== 4'h0) begin errors++; $display("FAIL zeraRod_prio got %h exp 0", db_rodada); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        zeraE = 1; zeraT = 1; tick(); zeraE = 0; zeraT = 0;
        contaE = 1; contaT = 1; tick(5); contaE = 0; contaT = 0;
        checks++; if (db_contagem !== 4'h5) begin errors++; $display("FAIL mid_E5 got %h exp 5", db_contagem); end
        botoes = 4'b1000; reset = 1; tick(); reset = 0;
        checks++; if (db_contagem !== 4'h0) begin errors++; $display("FAIL mid_reset_E got %h exp 0", db_contagem); end
        for (int i = 0; i < 4; i++) begin
            if (jogada === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL held_through_reset got %0d pulses exp 0", pulses); end
        contaT = 1; tick(6);
        checks++; if (fimT !== 1'b0) begin errors++; $display("FAIL mid_reset_T6 got %b exp 0", fimT); end
        tick(); contaT = 0;
        checks++; if (fimT !== 1'b1) begin errors++; $display("FAIL mid_reset_T7 got %b exp 1", fimT); end
        botoes = 4'h0; tick();
        botoes = 4'b1000; #1;
        checks++; if (jogada !== 1'b1) begin errors++; $display("FAIL post_reset_repress got %b exp 1", jogada); end
        tick(); botoes = 4'h0; tick();
    endtask

    initial begin
        test_reset();
        test_contaE();
        test_jogada();
        test_timeout();
        test_rodada();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
